outport: RTL and testbench

OUTPORT -- requirements
Module: outport

---
 rtl/outport_pkg.sv | 24 ++
 rtl/outport_rr_arbiter.sv | 23 ++
 rtl/outport.sv | 100 ++++++++++
 tb/tb_outport.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/outport_pkg.sv
// Shared router definitions: port count, flit width, diff-pair line encodings and FSM states.
package outport_pkg;
    localparam int PORTS  = 5;
    localparam int FLIT_W = 32;
    localparam int PTR_W  = 3;

    // {diff_pair_p, diff_pair_n}
    localparam logic [1:0] DP_IDLE  = 2'b01;
    localparam logic [1:0] DP_VALID = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [PORTS-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/outport_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr, wrapping mod PORTS.
module rr_arbiter
    import outport_pkg::*;
(
    input  logic [PORTS-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PORTS-1:0] grant
);
    logic [PTR_W-1:0] idx;

    // Scan from the farthest candidate down so the one nearest ptr wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % PORTS);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/outport.sv
// Router output port: arbitrates inports per packet, forwards flits against downstream credits.
// One registered cycle from arb_ack to output_channel; stalls with arb_ack low while credits are zero.
module outport
    import outport_pkg::*;
#(
    parameter int XCOR          = 2,
    parameter int YCOR          = 2,
    parameter int FLITS_PER_PKT = 4,
    parameter int CREDITS       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PORTS-1:0]        port_rqs,
    input  logic [PORTS*FLIT_W-1:0] channel_data_in,
    input  logic                    credit_in,
    output logic [PORTS-1:0]        arb_ack,
    output logic [FLIT_W-1:0]       output_channel,
    output logic                    diff_pair_p,
    output logic                    diff_pair_n
);
    localparam int CRD_W = $clog2(CREDITS + 1);
    localparam int CNT_W = $clog2(FLITS_PER_PKT + 1);

    state_t           state, state_nxt;
    logic [PTR_W-1:0] owner, ptr;
    logic [CNT_W-1:0] flit_cnt;
    logic [CRD_W-1:0] credits;
    logic [PORTS-1:0] grant;
    logic             send, last_flit, out_vld;

    rr_arbiter u_arb (
        .req   (port_rqs),
        .ptr   (ptr),
        .grant (grant)
    );

    assign last_flit = (flit_cnt == CNT_W'(FLITS_PER_PKT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|port_rqs)         state_nxt = ST_XFER;
            ST_XFER: if (send && last_flit) state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    // Gated by rst so a packet caught mid-flight stops acking in the reset cycle itself.
    always_comb begin
        send    = !rst && (state == ST_XFER) && (credits != '0);
        arb_ack = '0;
        if (send) arb_ack[owner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= '0;
            ptr      <= '0;
            flit_cnt <= '0;
        end else begin
            if (state == ST_IDLE && |port_rqs) owner <= onehot_to_idx(grant);
            if (send) begin
                if (last_flit) begin
                    flit_cnt <= '0;
                    ptr      <= (owner == PTR_W'(PORTS - 1)) ? '0 : owner + PTR_W'(1);
                end else begin
                    flit_cnt <= flit_cnt + CNT_W'(1);
                end
            end
        end
    end

    // A returned credit and a send in the same cycle cancel; returns beyond CREDITS are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= CRD_W'(CREDITS);
        end else if (send && !credit_in) begin
            credits <= credits - CRD_W'(1);
        end else if (!send && credit_in && credits != CRD_W'(CREDITS)) begin
            credits <= credits + CRD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            output_channel <= '0;
            out_vld        <= 1'b0;
        end else begin
            out_vld <= send;
            if (send) output_channel <= channel_data_in[int'(owner)*FLIT_W +: FLIT_W];
        end
    end

    assign {diff_pair_p, diff_pair_n} = out_vld ? DP_VALID : DP_IDLE;
endmodule

// File: tb/tb_outport.sv
// Self-checking bench for outport: packet-level reference model plus directed scenarios and random traffic.
module tb_outport;
    localparam int CR = 4;
    localparam int FP = 4;

    logic         clk = 1'b0;
    logic         rst, credit_in;
    logic [4:0]   port_rqs;
    logic [159:0] chan;
    logic [4:0]   arb_ack;
    logic [31:0]  output_channel;
    logic         dp_p, dp_n;

    logic         rst8, credit8;
    logic [4:0]   rqs8, ack8;
    logic [31:0]  out8;
    logic         p8, n8;

    always #5 clk = ~clk;

    outport dut (
        .clk(clk), .rst(rst), .port_rqs(port_rqs), .channel_data_in(chan),
        .credit_in(credit_in), .arb_ack(arb_ack), .output_channel(output_channel),
        .diff_pair_p(dp_p), .diff_pair_n(dp_n)
    );

    outport #(.FLITS_PER_PKT(8)) dut8 (
        .clk(clk), .rst(rst8), .port_rqs(rqs8), .channel_data_in(chan),
        .credit_in(credit8), .arb_ack(ack8), .output_channel(out8),
        .diff_pair_p(p8), .diff_pair_n(n8)
    );

    int errors = 0, checks = 0;
    int cyc = 0;
    bit chk_en = 0, rand_data = 0, rr_rec = 0;
    int grants[$];
    logic [4:0] prev_ack = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one packet in flight, credits as a plain integer.
    bit         m_busy = 0, m_vld = 0;
    int         m_owner = 0, m_ptr = 0, m_sent = 0, m_cred = CR;
    logic [31:0] m_out = '0;

    function automatic logic [4:0] m_ack();
        if (rst === 1'b0 && m_busy && m_cred > 0) return 5'(1 << m_owner);
        return 5'b0;
    endfunction

    always @(posedge clk) begin : model
        bit s, was_busy;
        if (rst) begin
            m_busy = 0; m_vld = 0; m_owner = 0; m_ptr = 0; m_sent = 0; m_cred = CR; m_out = '0;
        end else begin
            was_busy = m_busy;
            s = m_busy && m_cred > 0;
            m_vld = s;
            if (s) begin
                m_out = chan[m_owner*32 +: 32];
                m_sent++;
                if (m_sent == FP) begin
                    m_busy = 0; m_sent = 0; m_ptr = (m_owner + 1) % 5;
                end
            end
            if (!was_busy && port_rqs != 0) begin
                for (int k = 4; k >= 0; k--)
                    if (port_rqs[(m_ptr + k) % 5]) m_owner = (m_ptr + k) % 5;
                m_busy = 1;
            end
            if (s && !credit_in)                    m_cred--;
            else if (!s && credit_in && m_cred < CR) m_cred++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ack", arb_ack, m_ack());
            check("model_out", output_channel, m_out);
            check("model_pn", {dp_p, dp_n}, m_vld ? 2'b10 : 2'b01);
        end
        if (rr_rec && arb_ack != 0 && prev_ack == 0)
            for (int i = 0; i < 5; i++) if (arb_ack[i]) grants.push_back(i);
        prev_ack = arb_ack;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 5; i++)
            chan[i*32 +: 32] = rand_data ? $urandom : {8'(i), 24'(cyc)};
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(); rst = 1; port_rqs = 0; credit_in = 0;
        step(); rst = 0;
    endtask

    task automatic count_main(input int n, output int acks);
        acks = 0;
        repeat (n) begin step(); settle(); if (arb_ack != 0) acks++; end
    endtask

    int c0, a, pc;
    int rr_exp[6] = '{0, 1, 2, 3, 4, 0};
    logic [4:0]  acks_t[6];
    logic [31:0] outs_t[6];
    logic [1:0]  pns_t[6];

    initial begin
        rst = 1; port_rqs = 0; credit_in = 0; chan = '0;
        rst8 = 1; rqs8 = 0; credit8 = 0;

        // Reset values
        step(); settle();
        step(); chk_en = 1; settle();
        check("rst_ack", arb_ack, 5'b0);
        check("rst_out", output_channel, 32'h0);
        check("rst_pn", {dp_p, dp_n}, 2'b01);
        step(); rst = 0; rst8 = 0; credit_in = 1; settle();

        // Single requester, then pointer must sit at 3
        step(); port_rqs = 5'b00100; settle();
        check("t1_req_ack", arb_ack, 5'b0);
        c0 = cyc;
        for (int j = 1; j <= 5; j++) begin
            step();
            if (j == 5) port_rqs = 5'b11011;
            settle();
            acks_t[j] = arb_ack; outs_t[j] = output_channel; pns_t[j] = {dp_p, dp_n};
        end
        for (int j = 1; j <= 4; j++) check("t1_ack", acks_t[j], 5'b00100);
        check("t1_ack_end", acks_t[5], 5'b0);
        check("t1_pn_first", pns_t[1], 2'b01);
        for (int j = 2; j <= 5; j++) begin
            check("t1_pn", pns_t[j], 2'b10);
            check("t1_flit", outs_t[j], {8'd2, 24'(c0 + j - 1)});
        end
        step(); settle();
        check("t1_ptr", arb_ack, 5'b01000);
        port_rqs = 0;
        repeat (6) step();

        // Round-robin order with credits kept full
        do_reset(); credit_in = 1;
        grants.delete(); rr_rec = 1; port_rqs = 5'b11111;
        repeat (32) begin step(); settle(); end
        rr_rec = 0; port_rqs = 0;
        check("t2_count", 32'(grants.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++)
            if (i < grants.size()) check("t2_order", grants[i], rr_exp[i]);

        // Credit exhaustion on 8-flit packets
        step(); rst8 = 1;
        step(); rst8 = 0; rqs8 = 5'b00001; credit8 = 0;
        a = 0; pc = 0;
        repeat (12) begin step(); settle(); if (ack8 != 0) a++; if (p8) pc++; end
        check("t3_acks", a, 4);
        check("t3_flits", pc, 4);
        check("t3_stall_ack", ack8, 5'b0);
        check("t3_stall_pn", {p8, n8}, 2'b01);
        a = 0; pc = 0;
        step(); credit8 = 1; settle(); if (ack8 != 0) a++; if (p8) pc++;
        step(); credit8 = 0; settle(); if (ack8 != 0) a++; if (p8) pc++;
        repeat (5) begin step(); settle(); if (ack8 != 0) a++; if (p8) pc++; end
        check("t3_one_more_ack", a, 1);
        check("t3_one_more_flit", pc, 1);
        step(); rst8 = 1; rqs8 = 0;
        step(); rst8 = 0;

        // Simultaneous credit return and send at credits=2
        do_reset();
        step(); port_rqs = 5'b00001; settle();
        step(); settle();
        step(); settle();
        step(); credit_in = 1; settle();
        step(); credit_in = 0; settle();
        port_rqs = 5'b00010;
        count_main(10, a);
        check("t4_credits_left", a, 1);
        port_rqs = 0;

        // Credit return at full credits is dropped
        do_reset();
        step(); credit_in = 1; settle();
        step(); credit_in = 0; port_rqs = 5'b00001; settle();
        count_main(14, a);
        check("t4_saturate", a, 4);
        port_rqs = 0;

        // Request withdrawn after flit 2
        do_reset(); credit_in = 1;
        step(); port_rqs = 5'b00010; settle();
        step(); settle(); check("t5_f1", arb_ack, 5'b00010);
        step(); settle(); check("t5_f2", arb_ack, 5'b00010);
        step(); port_rqs = 0; settle(); check("t5_f3", arb_ack, 5'b00010);
        step(); settle(); check("t5_f4", arb_ack, 5'b00010);
        step(); settle(); check("t5_done", arb_ack, 5'b0);

        // Reset during flit 3
        do_reset(); credit_in = 0;
        step(); port_rqs = 5'b00001; settle();
        step(); settle();
        step(); settle();
        step(); rst = 1; settle();
        check("t6_ack_in_rst", arb_ack, 5'b0);
        step(); rst = 0; port_rqs = 0; settle();
        check("t6_ack", arb_ack, 5'b0);
        check("t6_out", output_channel, 32'h0);
        check("t6_pn", {dp_p, dp_n}, 2'b01);
        step(); port_rqs = 5'b00001; settle();
        count_main(10, a);
        check("t6_credits", a, 4);
        port_rqs = 0;

        // Random traffic against the model
        rand_data = 1;
        repeat (3000) begin
            step();
            port_rqs  = 5'($urandom);
            credit_in = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 199) == 0);
        end
        step(); rst = 0; port_rqs = 0;
        repeat (3) step();
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
